// File: rtl/axi_switch_arbiter.sv
// axi_switch_arbiter: round-robin owner of a shared AXI switch select.
// CS stays put until every accepted read and write has completed.
module axi_switch_arbiter #(
  parameter int NUM_SLAVE = 2,
  parameter int MAX_TXN   = 4
) (
  input  logic                 s_aclk,
  input  logic                 s_aresetn,
  input  logic [NUM_SLAVE-1:0] req_ar,
  input  logic [NUM_SLAVE-1:0] req_aw,
  input  logic                 m_axi_arvalid,
  input  logic                 m_axi_arready,
  input  logic                 m_axi_awvalid,
  input  logic                 m_axi_awready,
  input  logic                 m_axi_rvalid,
  input  logic                 m_axi_rready,
  input  logic                 m_axi_rlast,
  input  logic                 m_axi_bvalid,
  input  logic                 m_axi_bready,
  output logic [3:0]           CS,
  output logic [NUM_SLAVE-1:0] grant,
  output logic                 addr_en,
  output logic                 busy,
  output logic                 err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t r_state;
  state_t w_nstate;

  logic [3:0]           r_cs;
  logic [3:0]           r_last;
  logic [NUM_SLAVE-1:0] r_grant;
  logic                 r_addr_en;
  logic                 r_busy;
  logic                 r_err;
  logic [7:0]           r_rd;
  logic [7:0]           r_wr;
  logic [7:0]           r_txn;

  logic [NUM_SLAVE-1:0] w_req;
  logic [15:0]          w_req16;
  logic                 w_ar_hs;
  logic                 w_aw_hs;
  logic                 w_rd_done;
  logic                 w_wr_done;
  logic                 w_own_req;
  logic                 w_idle_err;
  logic                 w_cnt_err;
  logic [7:0]           w_rd;
  logic [7:0]           w_wr;
  logic [7:0]           w_txn;
  logic [8:0]           w_txn_sum;
  logic                 w_found;
  logic [3:0]           w_win;
  logic [4:0]           w_idx;
  logic [3:0]           w_cs_n;
  logic [3:0]           w_last_n;
  logic [NUM_SLAVE-1:0] w_grant_n;

  assign w_req      = req_ar | req_aw;
  assign w_req16    = 16'(w_req);
  assign w_ar_hs    = m_axi_arvalid & m_axi_arready & r_addr_en;
  assign w_aw_hs    = m_axi_awvalid & m_axi_awready & r_addr_en;
  assign w_rd_done  = m_axi_rvalid & m_axi_rready & m_axi_rlast;
  assign w_wr_done  = m_axi_bvalid & m_axi_bready;
  assign w_own_req  = |(w_req & r_grant);
  assign w_idle_err = (r_state == IDLE) &&
                      ((m_axi_arvalid & m_axi_arready) ||
                       (m_axi_awvalid & m_axi_awready));

  assign CS      = r_cs;
  assign grant   = r_grant;
  assign addr_en = r_addr_en;
  assign busy    = r_busy;
  assign err     = r_err;

  // Next outstanding counts; inc and dec together cancel out
  always_comb begin
    w_cnt_err = 1'b0;
    w_rd      = r_rd;
    w_wr      = r_wr;
    if (w_ar_hs && !w_rd_done) begin
      if (r_rd != 8'hFF) w_rd = r_rd + 8'd1;
    end else if (w_rd_done && !w_ar_hs) begin
      if (r_rd == 8'd0) w_cnt_err = 1'b1;
      else              w_rd = r_rd - 8'd1;
    end
    if (w_aw_hs && !w_wr_done) begin
      if (r_wr != 8'hFF) w_wr = r_wr + 8'd1;
    end else if (w_wr_done && !w_aw_hs) begin
      if (r_wr == 8'd0) w_cnt_err = 1'b1;
      else              w_wr = r_wr - 8'd1;
    end
    w_txn_sum = {1'b0, r_txn} + {8'd0, w_ar_hs} + {8'd0, w_aw_hs};
    w_txn     = w_txn_sum[8] ? 8'hFF : w_txn_sum[7:0];
  end

  // Round-robin search starting just after the last owner
  always_comb begin
    w_found = 1'b0;
    w_win   = 4'd0;
    w_idx   = 5'd0;
    for (int i = 0; i < NUM_SLAVE; i++) begin
      w_idx = 5'(r_last) + 5'(i) + 5'd1;
      if (w_idx >= 5'(NUM_SLAVE)) w_idx = w_idx - 5'(NUM_SLAVE);
      if (!w_found && w_req16[w_idx[3:0]]) begin
        w_found = 1'b1;
        w_win   = w_idx[3:0];
      end
    end
  end

  // State register
  always_ff @(posedge s_aclk or negedge s_aresetn) begin
    if (!s_aresetn) r_state <= IDLE;
    else            r_state <= w_nstate;
  end

  // Next-state decision using post-edge counter values
  always_comb begin
    w_nstate = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_found) w_nstate = GRANT;
      end
      GRANT: begin
        if (int'(w_txn) >= MAX_TXN)
          w_nstate = DRAIN;
        else if (!w_own_req)
          w_nstate = ((w_rd | w_wr) != 8'd0) ? DRAIN : IDLE;
      end
      DRAIN: begin
        if (w_rd == 8'd0 && w_wr == 8'd0) w_nstate = IDLE;
      end
      default: w_nstate = IDLE;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    w_cs_n   = r_cs;
    w_last_n = r_last;
    if (r_state == IDLE && w_found) w_cs_n = w_win;
    if (r_state != IDLE && w_nstate == IDLE) w_last_n = r_cs;
    w_grant_n = '0;
    for (int i = 0; i < NUM_SLAVE; i++)
      w_grant_n[i] = (w_nstate != IDLE) && (w_cs_n == 4'(i));
  end

  // Output, counter and priority registers
  always_ff @(posedge s_aclk or negedge s_aresetn) begin
    if (!s_aresetn) begin
      r_cs      <= 4'd0;
      r_last    <= 4'(NUM_SLAVE - 1);
      r_grant   <= '0;
      r_addr_en <= 1'b0;
      r_busy    <= 1'b0;
      r_err     <= 1'b0;
      r_rd      <= 8'd0;
      r_wr      <= 8'd0;
      r_txn     <= 8'd0;
    end else begin
      r_cs      <= w_cs_n;
      r_last    <= w_last_n;
      r_grant   <= w_grant_n;
      r_addr_en <= (w_nstate == GRANT);
      r_busy    <= (w_nstate != IDLE);
      r_err     <= r_err | w_cnt_err | w_idle_err;
      r_rd      <= w_rd;
      r_wr      <= w_wr;
      r_txn     <= (r_state == IDLE) ? 8'd0 : w_txn;
    end
  end

endmodule

// File: tb/tb_axi_switch_arbiter.sv
// tb_axi_switch_arbiter: directed scenarios then random traffic,
// every cycle compared against a transaction-level owner model.
module tb_axi_switch_arbiter;

  localparam int NS = 2;
  localparam int MT = 4;
  localparam int P_IDLE  = 0;
  localparam int P_OWN   = 1;
  localparam int P_DRAIN = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NS-1:0] req_ar = '0;
  logic [NS-1:0] req_aw = '0;
  logic arv = 0, arr = 0, awv = 0, awr = 0;
  logic rv = 0, rr = 0, rl = 0, bv = 0, br = 0;
  logic [3:0]    cs;
  logic [NS-1:0] gnt;
  logic          aen, bsy, er;

  int n_chk = 0;
  int n_err = 0;

  int m_phase, m_cs, m_last, m_rd, m_wr, m_txn;
  bit m_err;

  always #5 clk = ~clk;

  axi_switch_arbiter #(.NUM_SLAVE(NS), .MAX_TXN(MT)) u_dut (
    .s_aclk        (clk),
    .s_aresetn     (rst_n),
    .req_ar        (req_ar),
    .req_aw        (req_aw),
    .m_axi_arvalid (arv),
    .m_axi_arready (arr),
    .m_axi_awvalid (awv),
    .m_axi_awready (awr),
    .m_axi_rvalid  (rv),
    .m_axi_rready  (rr),
    .m_axi_rlast   (rl),
    .m_axi_bvalid  (bv),
    .m_axi_bready  (br),
    .CS            (cs),
    .grant         (gnt),
    .addr_en       (aen),
    .busy          (bsy),
    .err           (er)
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_phase = P_IDLE;
    m_cs    = 0;
    m_last  = NS - 1;
    m_rd    = 0;
    m_wr    = 0;
    m_txn   = 0;
    m_err   = 0;
  endtask

  // One clock of the owner model, from pre-edge inputs
  task automatic m_step();
    int har, haw, rdn, wdn, c;
    bit own;
    har = (arv && arr && m_phase == P_OWN) ? 1 : 0;
    haw = (awv && awr && m_phase == P_OWN) ? 1 : 0;
    rdn = (rv && rr && rl) ? 1 : 0;
    wdn = (bv && br) ? 1 : 0;
    if (m_phase == P_IDLE && ((arv && arr) || (awv && awr))) m_err = 1;
    m_rd = m_rd + har - rdn;
    m_wr = m_wr + haw - wdn;
    if (m_rd < 0) begin m_rd = 0; m_err = 1; end
    if (m_wr < 0) begin m_wr = 0; m_err = 1; end
    if (m_rd > 255) m_rd = 255;
    if (m_wr > 255) m_wr = 255;
    m_txn = m_txn + har + haw;
    if (m_txn > 255) m_txn = 255;
    case (m_phase)
      P_IDLE: begin
        for (int k = 1; k <= NS; k++) begin
          c = (m_last + k) % NS;
          if (m_phase == P_IDLE && (req_ar[c] || req_aw[c])) begin
            m_phase = P_OWN;
            m_cs    = c;
            m_txn   = 0;
          end
        end
      end
      P_OWN: begin
        own = req_ar[m_cs] || req_aw[m_cs];
        if (m_txn >= MT) m_phase = P_DRAIN;
        else if (!own) begin
          if (m_rd + m_wr > 0) m_phase = P_DRAIN;
          else begin m_phase = P_IDLE; m_last = m_cs; end
        end
      end
      default: begin
        if (m_rd == 0 && m_wr == 0) begin
          m_phase = P_IDLE;
          m_last  = m_cs;
        end
      end
    endcase
  endtask

  task automatic check_all(string tag);
    logic [NS-1:0] eg;
    eg = '0;
    if (m_phase != P_IDLE) eg[m_cs] = 1'b1;
    chk({tag, ".cs"},    cs,  m_cs);
    chk({tag, ".grant"}, gnt, eg);
    chk({tag, ".aen"},   aen, m_phase == P_OWN);
    chk({tag, ".busy"},  bsy, m_phase != P_IDLE);
    chk({tag, ".err"},   er,  m_err);
  endtask

  task automatic cyc(string tag);
    @(posedge clk);
    m_step();
    #1;
    check_all(tag);
  endtask

  initial begin
    m_reset();
    #12;
    chk("rst.cs", cs, 0);
    chk("rst.grant", gnt, 0);
    chk("rst.aen", aen, 0);
    chk("rst.busy", bsy, 0);
    chk("rst.err", er, 0);
    rst_n = 1'b1;

    // Basic grant to 0, one read, release, then requester 1
    req_ar = 2'b01;
    cyc("basic_gnt");
    chk("basic.cs0", cs, 0);
    chk("basic.gnt01", gnt, 2'b01);
    chk("basic.aen1", aen, 1);
    arv = 1; arr = 1;
    cyc("basic_ar");
    arv = 0; arr = 0;
    rv = 1; rr = 1; rl = 1; req_ar = 2'b00;
    cyc("basic_rlast");
    rv = 0; rr = 0; rl = 0;
    chk("basic.idle", bsy, 0);
    req_ar = 2'b10;
    cyc("basic_gnt1");
    chk("basic.cs1", cs, 1);
    req_ar = 2'b00;
    cyc("basic_rel1");

    // Quota: four reads of four beats each
    req_ar = 2'b11;
    cyc("quota_gnt");
    arv = 1; arr = 1;
    repeat (MT) cyc("quota_ar");
    arv = 0; arr = 0;
    chk("quota.aen0", aen, 0);
    chk("quota.cs_held", cs, 0);
    rv = 1; rr = 1;
    for (int b = 0; b < 16; b++) begin
      rl = ((b % 4) == 3);
      cyc("quota_r");
    end
    rv = 0; rr = 0; rl = 0;
    chk("quota.idle", bsy, 0);
    cyc("quota_next");
    chk("quota.next_cs1", cs, 1);
    req_ar = 2'b00;
    cyc("quota_rel");

    // Write held across a late B
    req_aw = 2'b01;
    cyc("wh_gnt");
    awv = 1; awr = 1;
    cyc("wh_aw");
    awv = 0; awr = 0; req_aw = 2'b00;
    cyc("wh_drain");
    repeat (20) begin
      cyc("wh_wait");
      chk("wh.cs_held", cs, 0);
    end
    bv = 1; br = 1;
    cyc("wh_b");
    bv = 0; br = 0;
    chk("wh.idle", bsy, 0);

    // Round robin with both requesters always asking
    req_aw = 2'b11;
    for (int g = 0; g < 4; g++) begin
      cyc("rr_gnt");
      chk("rr.cs", cs, (g % 2 == 0) ? 1 : 0);
      awv = 1; awr = 1;
      repeat (MT) cyc("rr_aw");
      awv = 0; awr = 0;
      chk("rr.quota_aen", aen, 0);
      bv = 1; br = 1;
      repeat (MT) cyc("rr_b");
      bv = 0; br = 0;
      chk("rr.gap", bsy, 0);
    end
    req_aw = 2'b00;
    cyc("rr_end");

    // Simultaneous inc/dec, then completion with nothing outstanding
    req_ar = 2'b01;
    cyc("sim_gnt");
    arv = 1; arr = 1;
    cyc("sim_ar");
    rv = 1; rr = 1; rl = 1;
    cyc("sim_both");
    chk("sim.no_err", er, 0);
    arv = 0; arr = 0;
    cyc("sim_last");
    rv = 0; rr = 0; rl = 0; req_ar = 2'b00;
    cyc("sim_rel");
    chk("sim.idle", bsy, 0);
    bv = 1; br = 1;
    cyc("sim_bad_b");
    bv = 0; br = 0;
    chk("sim.err_set", er, 1);
    repeat (3) cyc("sim_sticky");
    chk("sim.err_sticky", er, 1);

    // Reset while draining two reads
    req_ar = 2'b01;
    cyc("mr_gnt");
    arv = 1; arr = 1;
    repeat (2) cyc("mr_ar");
    arv = 0; arr = 0; req_ar = 2'b00;
    cyc("mr_drain");
    chk("mr.busy", bsy, 1);
    rst_n = 1'b0;
    #1;
    chk("mr.cs", cs, 0);
    chk("mr.grant", gnt, 0);
    chk("mr.aen", aen, 0);
    chk("mr.busy0", bsy, 0);
    chk("mr.err", er, 0);
    m_reset();
    #2;
    rst_n = 1'b1;
    req_ar = 2'b11;
    cyc("mr_first");
    chk("mr.first_cs0", cs, 0);
    chk("mr.first_gnt", gnt, 2'b01);
    req_ar = 2'b00;
    cyc("mr_rel");

    // Random traffic; no address handshake while idle, no spare completions
    for (int i = 0; i < 3000; i++) begin
      req_ar = NS'($urandom_range(0, (1 << NS) - 1));
      req_aw = NS'($urandom_range(0, (1 << NS) - 1));
      arv = (m_phase != P_IDLE) && ($urandom_range(0, 1) == 1);
      arr = ($urandom_range(0, 1) == 1);
      awv = (m_phase != P_IDLE) && ($urandom_range(0, 1) == 1);
      awr = ($urandom_range(0, 1) == 1);
      rv  = ($urandom_range(0, 1) == 1);
      rr  = ($urandom_range(0, 1) == 1);
      rl  = (m_rd > 0) && ($urandom_range(0, 2) == 0);
      bv  = (m_wr > 0) && ($urandom_range(0, 1) == 1);
      br  = ($urandom_range(0, 1) == 1);
      cyc("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/axi_switch_arbiter.md
AXI_SWITCH_ARBITER -- requirements
Module: axi_switch_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_SLAVE, default 2, meaning the number of requesters sharing one switch; legal range is 1..16.
REQ-002 The block SHALL have parameter MAX_TXN, default 4, meaning the number of address handshakes allowed per grant before forced re-arbitration; legal range is 1..255.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset: s_aclk and s_aresetn.
REQ-004 The block SHALL have the following ports:
- s_aclk  in  1  clock.
- s_aresetn  in  1  asynchronous active-low reset.
- req_ar  in  NUM_SLAVE  per-requester read request (requester's arvalid).
- req_aw  in  NUM_SLAVE  per-requester write request (requester's awvalid).
- m_axi_arvalid, m_axi_arready, m_axi_awvalid, m_axi_awready  in  1 each  switched master-side address handshake, observed only.
- m_axi_rvalid, m_axi_rready, m_axi_rlast  in  1 each  switched read-data handshake, observed only.
- m_axi_bvalid, m_axi_bready  in  1 each  switched write-response handshake, observed only.
- CS  out  4  select driven into the switch.
- grant  out  NUM_SLAVE  one-hot copy of CS; all zero when no requester is granted.
- addr_en  out  1  address-channel enable; integration ANDs it onto the switched arvalid/awvalid and arready/awready.
- busy  out  1  high whenever the FSM is not in IDLE.
- err  out  1  sticky protocol error flag.

Function
REQ-005 The block SHALL implement an FSM with states IDLE, GRANT and DRAIN; all outputs SHALL be registered.
REQ-006 In IDLE, the request vector SHALL be req = req_ar | req_aw.
REQ-007 In IDLE with any req bit set, the block SHALL select a winner by round-robin search starting at index last_grant+1 and wrapping modulo NUM_SLAVE.
REQ-008 On selecting a winner, on the next edge the block SHALL load CS and grant with the winner, set addr_en=1, clear txn_cnt, and enter GRANT; request-to-grant latency is 1 cycle.
REQ-009 In IDLE with no request, CS SHALL hold its last value, and grant and addr_en SHALL be 0.
REQ-010 An AR handshake SHALL be m_axi_arvalid & m_axi_arready & addr_en; it increments rd_cnt and txn_cnt.
REQ-011 An AW handshake SHALL be m_axi_awvalid & m_axi_awready & addr_en; it increments wr_cnt and txn_cnt.
REQ-012 A read completion (m_axi_rvalid & m_axi_rready & m_axi_rlast) SHALL decrement rd_cnt; a write completion (m_axi_bvalid & m_axi_bready) SHALL decrement wr_cnt.
REQ-013 A simultaneous increment and decrement on the same counter SHALL leave it unchanged; AR and AW handshakes in the same cycle SHALL add 2 to txn_cnt.
REQ-014 Counters rd_cnt, wr_cnt and txn_cnt SHALL each be 8 bits and saturate at 255; a decrement at 0 SHALL hold 0 and set err.
REQ-015 GRANT -> DRAIN (addr_en=0 on the next edge) SHALL occur when the next txn_cnt >= MAX_TXN.
REQ-016 GRANT -> DRAIN SHALL also occur when the grantee's req_ar and req_aw are both low and the next (rd_cnt+wr_cnt) is nonzero.
REQ-017 GRANT -> IDLE SHALL occur when the grantee's requests are both low and the next counters are zero; last_grant SHALL be updated to CS and grant cleared.
REQ-018 In DRAIN, the block SHALL hold addr_en=0 and hold CS until rd_cnt==0 and wr_cnt==0, then go to IDLE with last_grant updated to CS and grant cleared.
REQ-019 CS SHALL never change while rd_cnt or wr_cnt is nonzero.
REQ-020 W-channel beats SHALL be unaffected by addr_en; the switch SHALL stay held through a write burst via wr_cnt until B.
REQ-021 Requests from non-granted requesters SHALL be ignored outside IDLE; requests are level-held, with no queuing.
REQ-022 A handshake observed in IDLE SHALL set err.
REQ-023 A decrement in the same edge as an exit to IDLE SHALL be counted before the zero check.

Reset
REQ-024 On s_aresetn low, asynchronously: state=IDLE, CS=0, grant=0, addr_en=0, busy=0, err=0, all counters 0, last_grant=NUM_SLAVE-1 (first priority is index 0).
REQ-025 Reset mid-burst SHALL discard outstanding counts with no error; after release the block SHALL resume from IDLE on the first edge.

Verification
REQ-026 Basic grant: NUM_SLAVE=2, req_ar=2'b01 at cycle 0 -> CS=0, grant=01, addr_en=1, busy=1 at cycle 1; one AR handshake plus RLAST, then req drops -> IDLE; a later request from requester 1 is granted with CS=1.
REQ-027 Round-robin: req_aw=2'b11 continuously, one AW plus B per grant with MAX_TXN=1 -> grants alternate 0,1,0,1 with one IDLE cycle between grants.
REQ-028 Quota: MAX_TXN=4, requester 0 issues 4 ARlen=3 bursts -> addr_en=0 on the edge after the 4th AR; CS held until the 4th RLAST; then IDLE; requester 1 is granted next.
REQ-029 Write hold: AW accepted, requester drops req, B delayed 20 cycles -> DRAIN, CS unchanged for 20 cycles, IDLE on the cycle after B.
REQ-030 Simultaneity and errors: AR handshake and RLAST in the same cycle with rd_cnt=1 -> rd_cnt stays 1, err=0; forced B with wr_cnt=0 -> err=1 (sticky), wr_cnt=0.
REQ-031 Reset mid-operation: assert s_aresetn in DRAIN with rd_cnt=2 -> all outputs return to reset values immediately; the first request after release is granted to index 0.
